alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
- Multi-cycle execute sequencer that drives the existing combinational ALU. It is the producer side of the ALU's Rsrc/Rdest/OpCode -> Out/Flags interface.
- Accepts one decoded instruction per valid/ready handshake and reads operands from an internal 16x16 register file.
- Presents the operands and opcode to the ALU, writes the ALU result back, and latches the flags into a processor status register (PSR).
- Sits between the instruction decoder and the ALU in the datapath.

Parameters:
- NREGS, 16, register file depth; address width is clog2(NREGS) = 4.
- IDLE_OP, 5'b01111, opcode driven to the ALU while no instruction is executing (decodes to no operation).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  decoder has an instruction.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr_op  in  5  ALU opcode: ADD 0, SUB 1, CMP 2, AND 3, OR 4, XOR 5, NOT 6, LSH 7, RSH 8, ARSH 9.
- instr_rdest  in  4  destination / first-operand register index.
- instr_rsrc  in  4  source register index.
- instr_imm  in  16  immediate operand.
- instr_use_imm  in  1  1 = Rsrc operand is instr_imm instead of reg[instr_rsrc].
- alu_rsrc  out  16  to ALU Rsrc.
- alu_rdest  out  16  to ALU Rdest.
- alu_opcode  out  5  to ALU OpCode.
- alu_out  in  16  ALU result.
- alu_flags  in  5  ALU flags: [0]C [1]L [2]F [3]Z [4]N.
- psr  out  5  latched flags, same bit order.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse (with done) for an illegal opcode (>9).
- dbg_addr  in  4  debug read address.
- dbg_data  out  16  combinational read of reg[dbg_addr].

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; all registers, psr, alu_rsrc and alu_rdest clear to 0.
  - alu_opcode = IDLE_OP; done = err = 0; instr_ready = 1 after release.
- FSM states: IDLE -> OPR -> EXE -> WB -> IDLE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch op, rdest, rsrc, imm, use_imm and go to OPR. Otherwise stay.
- OPR:
  - Register alu_rdest = reg[rdest].
  - Register alu_rsrc = use_imm ? imm : reg[rsrc].
  - Register alu_opcode = op.
  - Illegal op: drive IDLE_OP instead.
- EXE:
  - ALU inputs held stable for one full cycle (ALU settle time).
  - Capture alu_out and alu_flags into internal result/flag registers at the end of the cycle.
- WB:
  - done = 1.
  - Result write-back: if op is not CMP and is legal, reg[rdest] <= captured result. CMP does not write back.
  - PSR update masks; unmasked bits hold:
    - ADD, SUB: C, F, Z, N.
    - CMP: L, Z, N; C is never taken from CMP.
    - AND, OR, XOR, NOT, LSH, RSH, ARSH: Z, N.
  - Illegal op: err = 1, no write-back, no psr change.
  - alu_opcode returns to IDLE_OP and the next state is IDLE.
- Latency: handshake on cycle N -> done on cycle N+3; the result is visible on dbg_data from cycle N+4. Throughput is one instruction per 4 cycles.
- instr_ready is low in OPR/EXE/WB. Changes on instr_* during those states are ignored.
- Same-register operands (rdest == rsrc) read the same pre-instruction value for both.
- A back-to-back dependent instruction needs no forwarding, because write-back completes before the next accept.
- Arithmetic is 16-bit wrap-around inside the ALU; the sequencer never extends widths.
- Reset asserted mid-instruction aborts with no write-back; the register file is cleared and there is no partial psr update.
- dbg_data is combinational and returns the pre-write value during the WB cycle.

Test Plan:
- Reset then ADD r1 = r1 + imm 0x0005 (use_imm = 1) -> done 3 cycles after accept; r1 = 0x0005; psr.Z = 0, psr.N = 0; instr_ready low for exactly 3 cycles.
- r2 = 0xFFF0, ADD imm 0x0010 -> r2 = 0x0000; psr.C = 1, psr.Z = 1; then a CMP leaves psr.C = 1.
- r3 = 0x4000, ADD r3, r3 -> r3 = 0x8000; psr.F = 1, psr.N = 1.
- CMP r4 = 4 against r5 = 2 -> r4 and r5 unchanged; psr.L/Z/N match the ALU outputs for these operands; done pulses, no write-back.
- instr_op = 5'd12 -> err and done pulse together; registers and psr unchanged; alu_opcode stays IDLE_OP throughout.
- Start ADD, pull rst_n low in the EXE cycle -> all registers 0, psr 0, state IDLE. Also: instr_valid held high across 3 instructions -> exactly 3 accepts, 4 cycles apart.

Source files
------------

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: four-phase execute sequencer that drives the combinational ALU.
// Ports: instr_* decoder handshake in. alu_* operands and opcode out, result and flags in.
//        psr holds the latched flags. done/err are retire pulses. dbg_addr/dbg_data peek the regfile.
module alu_exec_seq #(
    parameter int         NREGS   = 16,
    parameter logic [4:0] IDLE_OP = 5'b01111,
    localparam int        AW      = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [4:0]    instr_op,
    input  logic [AW-1:0] instr_rdest,
    input  logic [AW-1:0] instr_rsrc,
    input  logic [15:0]   instr_imm,
    input  logic          instr_use_imm,
    output logic [15:0]   alu_rsrc,
    output logic [15:0]   alu_rdest,
    output logic [4:0]    alu_opcode,
    input  logic [15:0]   alu_out,
    input  logic [4:0]    alu_flags,
    output logic [4:0]    psr,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data
);
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_CMP = 5'd2;
    localparam logic [4:0] OP_MAX = 5'd9;

    typedef enum logic [1:0] {IDLE, OPR, EXE, WB} state_t;

    state_t        state;
    state_t        state_nx;
    logic [4:0]    op_q;
    logic [AW-1:0] rdest_q;
    logic [AW-1:0] rsrc_q;
    logic [15:0]   imm_q;
    logic          use_imm_q;
    logic [15:0]   res_q;
    logic [4:0]    flg_q;
    logic [15:0]   regs [NREGS];
    logic          legal;
    logic          wr_en;
    logic [4:0]    psr_mask;

    assign legal    = (op_q <= OP_MAX);
    assign wr_en    = (state == WB) && legal && (op_q != OP_CMP);
    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nx = OPR;
            end
            OPR: state_nx = EXE;
            EXE: state_nx = WB;
            WB: begin
                done     = 1'b1;
                err      = !legal;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Flags a class of op owns; everything else in psr keeps its value.
    // CMP never owns C, so a carry survives compares.
    always_comb begin
        psr_mask = 5'b00000;
        if (legal) begin
            if (op_q == OP_ADD || op_q == OP_SUB) psr_mask = 5'b11101;
            else if (op_q == OP_CMP)              psr_mask = 5'b11010;
            else                                  psr_mask = 5'b11000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            rdest_q    <= '0;
            rsrc_q     <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            res_q      <= '0;
            flg_q      <= '0;
            psr        <= '0;
            alu_rsrc   <= '0;
            alu_rdest  <= '0;
            alu_opcode <= IDLE_OP;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (state == IDLE && instr_valid) begin
                op_q      <= instr_op;
                rdest_q   <= instr_rdest;
                rsrc_q    <= instr_rsrc;
                imm_q     <= instr_imm;
                use_imm_q <= instr_use_imm;
            end
            if (state == OPR) begin
                alu_rdest  <= regs[rdest_q];
                alu_rsrc   <= use_imm_q ? imm_q : regs[rsrc_q];
                alu_opcode <= legal ? op_q : IDLE_OP;
            end
            // Capture at the end of the settle cycle, then park the ALU.
            if (state == EXE) begin
                res_q      <= alu_out;
                flg_q      <= alu_flags;
                alu_opcode <= IDLE_OP;
            end
            if (state == WB) begin
                if (wr_en) regs[rdest_q] <= res_q;
                psr <= (psr & ~psr_mask) | (flg_q & psr_mask);
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: directed bench with an ALU model, a per-instruction
// reference model and a per-cycle compare against the sequencer.
module tb_alu_exec_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [4:0]  instr_op = '0;
    logic [3:0]  instr_rdest = '0;
    logic [3:0]  instr_rsrc = '0;
    logic [15:0] instr_imm = '0;
    logic        instr_use_imm = 1'b0;
    logic [15:0] alu_rsrc;
    logic [15:0] alu_rdest;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_out;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done;
    logic        err;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int n_chk = 0;
    int n_pass = 0;
    bit run = 1'b0;

    alu_exec_seq dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rdest(instr_rdest),
        .instr_rsrc(instr_rsrc), .instr_imm(instr_imm),
        .instr_use_imm(instr_use_imm),
        .alu_rsrc(alu_rsrc), .alu_rdest(alu_rdest),
        .alu_opcode(alu_opcode), .alu_out(alu_out),
        .alu_flags(alu_flags), .psr(psr), .done(done), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // ALU behaviour: {result, N, Z, F, L, C}
    function automatic logic [20:0] alu_f(input logic [4:0] op,
                                          input logic [15:0] d,
                                          input logic [15:0] s);
        logic [16:0] w;
        logic [15:0] r;
        logic c, l, f, z, n;
        l = (d < s);
        c = 1'b0;
        f = 1'b0;
        r = '0;
        case (op)
            5'd0: begin
                w = {1'b0, d} + {1'b0, s};
                r = w[15:0];
                c = w[16];
                f = (d[15] == s[15]) && (r[15] != d[15]);
            end
            5'd1: begin
                r = d - s;
                c = (d < s);
                f = (d[15] != s[15]) && (r[15] != d[15]);
            end
            5'd2: r = d - s;
            5'd3: r = d & s;
            5'd4: r = d | s;
            5'd5: r = d ^ s;
            5'd6: r = ~s;
            5'd7: r = d << s[3:0];
            5'd8: r = d >> s[3:0];
            5'd9: r = 16'($signed(d) >>> s[3:0]);
            default: return {16'hDEAD, 5'h1F};
        endcase
        z = (r == 16'h0);
        n = r[15];
        if (op == 5'd2) begin
            z = (d == s);
            n = ($signed(d) < $signed(s));
        end
        return {r, n, z, f, l, c};
    endfunction

    function automatic logic [15:0] res_f(input logic [4:0] op,
                                          input logic [15:0] d,
                                          input logic [15:0] s);
        logic [20:0] t;
        t = alu_f(op, d, s);
        return t[20:5];
    endfunction

    function automatic logic [4:0] flg_f(input logic [4:0] op,
                                         input logic [15:0] d,
                                         input logic [15:0] s);
        logic [20:0] t;
        t = alu_f(op, d, s);
        return t[4:0];
    endfunction

    function automatic logic [4:0] mask_f(input logic [4:0] op);
        if (op <= 5'd1) return 5'b11101;
        if (op == 5'd2) return 5'b11010;
        if (op <= 5'd9) return 5'b11000;
        return 5'b00000;
    endfunction

    always_comb begin
        {alu_out, alu_flags} = alu_f(alu_opcode, alu_rdest, alu_rsrc);
    end

    // Reference model: an instruction retires three edges after acceptance.
    int          cyc = 0;
    int          mage = -1;
    int          n_acc = 0;
    int          acc_cyc [64];
    logic [15:0] mreg [16];
    logic [4:0]  mpsr = '0;
    logic [4:0]  m_op = '0;
    logic [3:0]  m_rd = '0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mreg[i] <= '0;
            mpsr <= '0;
            mage <= -1;
        end else if (mage < 0) begin
            if (instr_valid) begin
                m_op  <= instr_op;
                m_rd  <= instr_rdest;
                m_a   <= mreg[instr_rdest];
                m_b   <= instr_use_imm ? instr_imm : mreg[instr_rsrc];
                mage  <= 0;
                acc_cyc[n_acc % 64] <= cyc;
                n_acc <= n_acc + 1;
            end
        end else if (mage == 2) begin
            if (m_op <= 5'd9 && m_op != 5'd2)
                mreg[m_rd] <= res_f(m_op, m_a, m_b);
            mpsr <= (mpsr & ~mask_f(m_op))
                  | (flg_f(m_op, m_a, m_b) & mask_f(m_op));
            mage <= -1;
        end else begin
            mage <= mage + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && run) begin
            chk("ready", instr_ready, mage < 0);
            chk("done", done, mage == 2);
            chk("err", err, mage == 2 && m_op > 5'd9);
            chk("alu_opcode", alu_opcode,
                (mage == 1 && m_op <= 5'd9) ? m_op : 5'd15);
            chk("psr", psr, mpsr);
            chk("dbg_data", dbg_data, mreg[dbg_addr]);
            if (mage == 1) begin
                chk("alu_rdest", alu_rdest, m_a);
                chk("alu_rsrc", alu_rsrc, m_b);
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [3:0] rd,
                         input logic [3:0] rs, input logic [15:0] imm,
                         input logic ui);
        int a0;
        a0 = n_acc;
        instr_op = op;
        instr_rdest = rd;
        instr_rsrc = rs;
        instr_imm = imm;
        instr_use_imm = ui;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && n_acc == a0; i++) begin
            @(posedge clk); #2;
        end
        if (n_acc == a0) chk("accept_timeout", 1, 0);
        instr_valid = 1'b0;
        // Busy-phase input noise must be ignored.
        instr_op = 5'd4;
        instr_rdest = ~rd;
        instr_rsrc = ~rs;
        instr_imm = 16'h5A5A;
        instr_use_imm = ~ui;
        for (int i = 0; i < 20 && mage >= 0; i++) begin
            @(posedge clk); #2;
        end
        if (mage >= 0) chk("retire_timeout", 1, 0);
    endtask

    task automatic peek(input string nm, input logic [3:0] a,
                        input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(nm, dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_psr", psr, 5'h00);
        chk("rst_opcode", alu_opcode, 5'd15);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        run = 1'b1;
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_alu_rsrc", alu_rsrc, 16'h0);

        issue(5'd0, 4'd1, 4'd0, 16'h0005, 1'b1);
        peek("add_r1", 4'd1, 16'h0005);
        chk("add_psr", psr, 5'h00);

        issue(5'd0, 4'd2, 4'd0, 16'hFFF0, 1'b1);
        chk("ld_r2_psr", psr, 5'h10);
        issue(5'd0, 4'd2, 4'd0, 16'h0010, 1'b1);
        peek("wrap_r2", 4'd2, 16'h0000);
        chk("wrap_psr", psr, 5'h09);
        issue(5'd2, 4'd1, 4'd2, 16'h0000, 1'b0);
        chk("cmp_keeps_c", psr, 5'h01);

        issue(5'd0, 4'd3, 4'd0, 16'h4000, 1'b1);
        issue(5'd0, 4'd3, 4'd3, 16'h0000, 1'b0);
        peek("ovf_r3", 4'd3, 16'h8000);
        chk("ovf_psr", psr, 5'h14);

        issue(5'd0, 4'd4, 4'd0, 16'h0004, 1'b1);
        issue(5'd0, 4'd5, 4'd0, 16'h0002, 1'b1);
        issue(5'd2, 4'd4, 4'd5, 16'h0000, 1'b0);
        peek("cmp_r4", 4'd4, 16'h0004);
        peek("cmp_r5", 4'd5, 16'h0002);
        chk("cmp_gt_psr", psr, 5'h00);
        issue(5'd2, 4'd5, 4'd4, 16'h0000, 1'b0);
        chk("cmp_lt_psr", psr, 5'h12);

        issue(5'd5, 4'd1, 4'd0, 16'h0005, 1'b1);
        peek("xor_r1", 4'd1, 16'h0000);
        chk("xor_psr", psr, 5'h0A);

        issue(5'd1, 4'd6, 4'd0, 16'h0001, 1'b1);
        peek("sub_r6", 4'd6, 16'hFFFF);
        chk("sub_psr", psr, 5'h13);
        issue(5'd9, 4'd6, 4'd0, 16'h0004, 1'b1);
        peek("arsh_r6", 4'd6, 16'hFFFF);
        issue(5'd7, 4'd4, 4'd0, 16'h0002, 1'b1);
        peek("lsh_r4", 4'd4, 16'h0010);
        chk("lsh_psr", psr, 5'h03);
        issue(5'd6, 4'd8, 4'd5, 16'h0000, 1'b0);
        peek("not_r8", 4'd8, 16'hFFFD);
        issue(5'd8, 4'd8, 4'd0, 16'h0008, 1'b1);
        peek("rsh_r8", 4'd8, 16'h00FF);
        issue(5'd4, 4'd9, 4'd4, 16'h0000, 1'b0);
        issue(5'd3, 4'd9, 4'd0, 16'h0030, 1'b1);
        peek("andor_r9", 4'd9, 16'h0010);
        chk("andor_psr", psr, 5'h03);

        issue(5'd12, 4'd4, 4'd5, 16'h1234, 1'b1);
        peek("ill_r4", 4'd4, 16'h0010);
        chk("ill_psr", psr, 5'h03);

        begin
            int a0;
            a0 = n_acc;
            instr_op = 5'd0;
            instr_rdest = 4'd7;
            instr_rsrc = 4'd0;
            instr_imm = 16'h0001;
            instr_use_imm = 1'b1;
            instr_valid = 1'b1;
            for (int i = 0; i < 40 && n_acc < a0 + 3; i++) begin
                @(posedge clk); #2;
            end
            instr_valid = 1'b0;
            chk("b2b_accepts", n_acc - a0, 3);
            chk("b2b_gap1", acc_cyc[(a0 + 1) % 64] - acc_cyc[a0 % 64], 4);
            chk("b2b_gap2", acc_cyc[(a0 + 2) % 64] - acc_cyc[(a0 + 1) % 64], 4);
            for (int i = 0; i < 20 && mage >= 0; i++) begin
                @(posedge clk); #2;
            end
            peek("b2b_r7", 4'd7, 16'h0003);
        end

        begin
            int a0;
            a0 = n_acc;
            instr_op = 5'd0;
            instr_rdest = 4'd3;
            instr_rsrc = 4'd0;
            instr_imm = 16'h0001;
            instr_use_imm = 1'b1;
            instr_valid = 1'b1;
            for (int i = 0; i < 20 && n_acc == a0; i++) begin
                @(posedge clk); #2;
            end
            instr_valid = 1'b0;
            @(posedge clk); #2;
            chk("abort_in_exe", alu_opcode, 5'd0);
            rst_n = 1'b0;
            #1;
            chk("abort_psr", psr, 5'h00);
            chk("abort_opcode", alu_opcode, 5'd15);
            chk("abort_done", done, 0);
            @(posedge clk); #2;
            rst_n = 1'b1;
            #1;
            chk("abort_ready", instr_ready, 1);
            for (int i = 0; i < 16; i++) peek("abort_reg", 4'(i), 16'h0);
            repeat (6) @(posedge clk);
            #2;
            chk("abort_no_wb", psr, 5'h00);
        end

        @(negedge clk);
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
